// File: rtl/serial_word_comparator.sv
// serial_word_comparator
//   Accumulates a full-word magnitude verdict from per-digit compare flags.
//   Each handshake delivers one 2-bit digit pair. The verdict is held under a
//   valid/ready handshake until downstream consumes it.
//   Optional build macro SERIAL_WORD_COMPARATOR_LSB_FIRST_EN: digits arrive
//   LSB-first and the last non-equal digit decides. When the macro is
//   undefined, digits arrive MSB-first and the first non-equal digit decides.
module serial_word_comparator #(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic digit_valid_in,
    output logic digit_ready,
    input  logic is_greater_in,
    input  logic is_equal_in,
    input  logic is_less_in,
    output logic result_valid,
    input  logic result_ready_in,
    output logic word_greater,
    output logic word_equal,
    output logic word_less,
    output logic word_error
);

    localparam int unsigned      CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DONE  = 1'b1;

    localparam logic [1:0] DEC_EQ = 2'b00;
    localparam logic [1:0] DEC_GT = 2'b01;
    localparam logic [1:0] DEC_LT = 2'b10;

    logic [0:0]       state;
    logic [CNT_W-1:0] digit_cnt;
    logic [1:0]       decision;
    logic [1:0]       decision_next;
    logic             error_flag;
    logic             error_next;
    logic [2:0]       flags;
    logic             flags_legal;
    logic             digit_gt;
    logic             digit_lt;
    logic             accept;
    logic             consume;
    logic             last_digit;

    // Handshake outputs come straight from the registered state.
    assign digit_ready  = (state == ACCUM);
    assign result_valid = (state == DONE);

    assign accept     = digit_valid_in && digit_ready;
    assign consume    = result_valid && result_ready_in;
    assign last_digit = (digit_cnt == LAST_DIGIT);

    // A digit is only meaningful when exactly one flag is raised.
    assign flags       = {is_greater_in, is_equal_in, is_less_in};
    assign flags_legal = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    assign digit_gt    = flags_legal && is_greater_in;
    assign digit_lt    = flags_legal && is_less_in;

    // Decision the accumulator takes if the current digit is accepted.
    always_comb begin
        decision_next = decision;
        error_next    = error_flag | ~flags_legal;
`ifdef SERIAL_WORD_COMPARATOR_LSB_FIRST_EN
        // LSB-first: later digits are more significant, so any non-equal digit overwrites.
        if (digit_gt) begin
            decision_next = DEC_GT;
        end else if (digit_lt) begin
            decision_next = DEC_LT;
        end
`else
        // MSB-first: the first non-equal digit locks the decision.
        if (decision == DEC_EQ) begin
            if (digit_gt) begin
                decision_next = DEC_GT;
            end else if (digit_lt) begin
                decision_next = DEC_LT;
            end
        end
`endif
    end

    // FSM and digit counter: ACCUM collects NUM_DIGITS digits, DONE waits for consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            digit_cnt <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (last_digit) begin
                            digit_cnt <= '0;
                            state     <= DONE;
                        end else begin
                            digit_cnt <= digit_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (consume) begin
                        state <= ACCUM;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    digit_cnt <= '0;
                end
            endcase
        end
    end

    // Accumulator: decision plus sticky error, cleared at the start of each word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decision   <= DEC_EQ;
            error_flag <= 1'b0;
        end else if (consume) begin
            decision   <= DEC_EQ;
            error_flag <= 1'b0;
        end else if (accept) begin
            decision   <= decision_next;
            error_flag <= error_next;
        end
    end

    // Verdict registers: loaded with the post-update decision on the final digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_greater <= 1'b0;
            word_equal   <= 1'b0;
            word_less    <= 1'b0;
            word_error   <= 1'b0;
        end else if (accept && last_digit) begin
            word_greater <= (decision_next == DEC_GT);
            word_equal   <= (decision_next == DEC_EQ);
            word_less    <= (decision_next == DEC_LT);
            word_error   <= error_next;
        end else if (consume) begin
            word_greater <= 1'b0;
            word_equal   <= 1'b0;
            word_less    <= 1'b0;
            word_error   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_comparator.sv
// tb_serial_word_comparator
//   Directed and random words for serial_word_comparator (NUM_DIGITS=4).
//   Expected verdicts come from comparing the two operand words arithmetically.
//   Any illegal digit has its position zeroed in both operands, which makes
//   that digit equal. Build with SERIAL_WORD_COMPARATOR_LSB_FIRST_EN to present
//   digits LSB-first.
module tb_serial_word_comparator;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;
    logic digit_valid_in;
    logic digit_ready;
    logic is_greater_in;
    logic is_equal_in;
    logic is_less_in;
    logic result_valid;
    logic result_ready_in;
    logic word_greater;
    logic word_equal;
    logic word_less;
    logic word_error;

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] flags [N];
    logic [3:0] exp_v;

    serial_word_comparator #(.NUM_DIGITS(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .digit_valid_in  (digit_valid_in),
        .digit_ready     (digit_ready),
        .is_greater_in   (is_greater_in),
        .is_equal_in     (is_equal_in),
        .is_less_in      (is_less_in),
        .result_valid    (result_valid),
        .result_ready_in (result_ready_in),
        .word_greater    (word_greater),
        .word_equal      (word_equal),
        .word_less       (word_less),
        .word_error      (word_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input string what, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, what, obs, exp);
        end
    endtask

    // Flags for each presented digit, plus the expected {gt,eq,lt,err} word verdict.
    task automatic build(input logic [2*N-1:0] a, input logic [2*N-1:0] b,
                         input int ill_pos, input logic [2:0] ill_pat);
        int unsigned ma;
        int unsigned mb;
        int          k;
        logic [1:0]  da;
        logic [1:0]  db;
        ma = a;
        mb = b;
        for (int i = 0; i < N; i++) begin
`ifdef SERIAL_WORD_COMPARATOR_LSB_FIRST_EN
            k = i;
`else
            k = N - 1 - i;
`endif
            da = a[2*k +: 2];
            db = b[2*k +: 2];
            flags[i] = (da > db) ? 3'b100 : (da == db) ? 3'b010 : 3'b001;
            if (i == ill_pos) begin
                flags[i] = ill_pat;
                ma = ma & ~(32'd3 << (2 * k));
                mb = mb & ~(32'd3 << (2 * k));
            end
        end
        exp_v = {ma > mb, ma == mb, ma < mb, ill_pos >= 0};
    endtask

    // Presents the built digits, then holds the verdict for 'hold' extra cycles
    // while presenting 'held' with digit_valid_in=1 (it must not be consumed).
    task automatic run_word(input string tag, input int hold, input logic [2:0] held);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check(tag, "digit_ready", {3'b0, digit_ready}, 4'b0001);
            check(tag, "result_valid_low", {3'b0, result_valid}, 4'b0000);
            check(tag, "verdict_idle", {word_greater, word_equal, word_less, word_error}, 4'b0000);
            digit_valid_in = 1'b1;
            {is_greater_in, is_equal_in, is_less_in} = flags[i];
            result_ready_in = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c <= hold; c++) begin
            @(negedge clk);
            check(tag, "result_valid", {3'b0, result_valid}, 4'b0001);
            check(tag, "digit_ready_low", {3'b0, digit_ready}, 4'b0000);
            check(tag, "verdict", {word_greater, word_equal, word_less, word_error}, exp_v);
            digit_valid_in = 1'b1;
            {is_greater_in, is_equal_in, is_less_in} = held;
            result_ready_in = (c == hold);
        end
    endtask

    initial begin
        logic [2*N-1:0] a;
        logic [2*N-1:0] b;
        int             pos;
        logic [2:0]     pat;
        logic [2:0]     ill_tab [5];
        ill_tab[0] = 3'b000; ill_tab[1] = 3'b011; ill_tab[2] = 3'b101;
        ill_tab[3] = 3'b110; ill_tab[4] = 3'b111;

        // Reset held with a digit presented; nothing may be accepted.
        rst = 1'b1;
        digit_valid_in = 1'b1;
        {is_greater_in, is_equal_in, is_less_in} = 3'b100;
        result_ready_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset", "digit_ready", {3'b0, digit_ready}, 4'b0001);
            check("reset", "result_valid", {3'b0, result_valid}, 4'b0000);
            check("reset", "verdict", {word_greater, word_equal, word_less, word_error}, 4'b0000);
        end
        rst = 1'b0;
        digit_valid_in = 1'b0;

        // Greater word.
        build(8'hB4, 8'hB1, -1, 3'b000);
        run_word("greater", 0, 3'b100);

        // Equal then less, back to back.
        build(8'h5A, 8'h5A, -1, 3'b000);
        run_word("equal", 0, 3'b001);
        build(8'h3F, 8'hC0, -1, 3'b000);
        run_word("less", 0, 3'b010);

        // Backpressure: held digit is the next word's first (EQ) digit.
        build(8'hB4, 8'hB1, -1, 3'b000);
        run_word("backpressure", 6, 3'b010);
        build(8'h77, 8'h77, -1, 3'b000);
        run_word("after_bp", 0, 3'b100);

        // Illegal flags on digit 1, then a clean word.
        build(8'h5A, 8'h5A, 1, 3'b000);
        run_word("illegal", 0, 3'b100);
        build(8'h12, 8'h21, -1, 3'b000);
        run_word("clean", 0, 3'b100);

        // Mid-word reset after two accepted digits.
        @(negedge clk);
        check("midrst", "digit_ready", {3'b0, digit_ready}, 4'b0001);
        digit_valid_in = 1'b1;
        {is_greater_in, is_equal_in, is_less_in} = 3'b100;
        @(negedge clk);
        {is_greater_in, is_equal_in, is_less_in} = 3'b010;
        @(negedge clk);
        digit_valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        build(8'h00, 8'h00, -1, 3'b000);
        run_word("midrst", 0, 3'b100);

        // Random words with random backpressure and occasional illegal digits.
        for (int w = 0; w < 40; w++) begin
            a = (2*N)'($urandom);
            b = (2*N)'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            pos = -1;
            pat = 3'b000;
            if ($urandom_range(0, 3) == 0) begin
                pos = $urandom_range(0, N - 1);
                pat = ill_tab[$urandom_range(0, 4)];
            end
            build(a, b, pos, pat);
            run_word("random", $urandom_range(0, 3), 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        check("final", "result_valid", {3'b0, result_valid}, 4'b0000);
        check("final", "verdict", {word_greater, word_equal, word_less, word_error}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_word_comparator.md
# serial_word_comparator

Sequential stage directly downstream of `comparator_two_bit`. It consumes that comparator's per-digit `is_greater`/`is_equal`/`is_less` flags, one 2-bit digit pair per handshake. Over `NUM_DIGITS` digits it accumulates a full-word magnitude verdict for two `2*NUM_DIGITS`-bit operands. It then holds the verdict under a valid/ready handshake until downstream takes it.

## Interface
- `NUM_DIGITS`, default 4: digit pairs per word. Legal range 1..16. Counter width is max(1, $clog2(NUM_DIGITS)).
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `digit_valid_in` input 1: a digit's compare flags are present this cycle.
- `digit_ready` output 1: block accepts a digit this cycle.
- `is_greater_in` input 1: digit flag A_in > B_in, from the comparator.
- `is_equal_in` input 1: digit flag A_in == B_in.
- `is_less_in` input 1: digit flag A_in < B_in.
- `result_valid` output 1: word verdict is presented.
- `result_ready_in` input 1: downstream consumes the verdict.
- `word_greater` output 1: word A > word B.
- `word_equal` output 1: word A == word B.
- `word_less` output 1: word A < word B.
- `word_error` output 1: at least one digit of this word carried non-one-hot flags.

## Operation
- Digit accept: `digit_valid_in && digit_ready` on a rising edge of `clk`.
- The FSM has two states.
  - ACCUM: `digit_ready`=1, `result_valid`=0. Each accepted digit updates the accumulator and increments `digit_cnt`. When the accepted digit has `digit_cnt == NUM_DIGITS-1`, the FSM goes to DONE and `digit_cnt` wraps to 0.
  - DONE: `digit_ready`=0, `result_valid`=1. When `result_ready_in`=1, the FSM returns to ACCUM, the accumulator clears to "equal, no error", and the verdict outputs return to 0.
- Accumulator: a 2-bit decision register (EQ, GT, LT) plus a sticky error bit. It clears to EQ/no-error at the start of every word.
- Default digit order is MSB-first. The first non-equal digit decides the word.
  - While the decision is EQ, an accepted GT digit sets GT and an accepted LT digit sets LT.
  - Once the decision is GT or LT, later digits do not change it.
- Illegal digit: flags not exactly one-hot (000, 011, 101, 110, 111).
  - The sticky error bit is set.
  - The digit is treated as equal and leaves the decision unchanged.
  - Digit count advances normally.
- Verdict outputs are registered and driven only in DONE. Exactly one of `word_greater`/`word_equal`/`word_less` is 1. `word_error` is valid alongside them.
- `digit_valid_in` in DONE is ignored and the digit is not consumed. Upstream holds its digit until `digit_ready`.
- `result_ready_in` while `result_valid`=0 is ignored.
- `rst` asserted mid-word discards the partial word, count and error.

## Timing
- Reset values: state ACCUM, `digit_cnt`=0, `digit_ready`=1, `result_valid`=0, `word_greater`=`word_equal`=`word_less`=0, `word_error`=0. Digits presented while `rst`=1 are not accepted.
- `digit_ready` and `result_valid` are decoded from registered state only, with no combinational path from any input.
- Latency: `result_valid` rises on the edge that accepts digit NUM_DIGITS-1, so it is visible the cycle after that digit is presented.
- Throughput: with `result_ready_in` tied to 1, one word takes NUM_DIGITS + 1 cycles, because DONE costs one bubble cycle.
- In DONE, the verdict and `word_error` are stable until the consuming edge.
- Input flags are sampled only on accepting edges. Their value in other cycles is don't-care.

## Configuration
- Macro: `SERIAL_WORD_COMPARATOR_LSB_FIRST_EN`.
- Undefined: digits arrive MSB-first and the first non-equal digit wins, as in Operation.
- Defined: digits arrive LSB-first and the last non-equal digit wins.
  - Every accepted GT or LT digit overwrites the decision.
  - An EQ or illegal digit leaves it unchanged.
  - All other behaviour, handshake and timing are identical.

## Test plan
All scenarios use NUM_DIGITS=4. Digit sequences are listed in the configured order.
- Reset: hold `rst`=1 for 3 cycles with `digit_valid_in`=1. Required: no digit accepted, `digit_ready`=1, `result_valid`=0, all verdicts 0 after release.
- Greater word: A=8'hB4, B=8'hB1 (MSB-first flags EQ, EQ, GT, LT; LSB-first flags LT, GT, EQ, EQ), `result_ready_in`=1. Required in both builds: `word_greater`=1, `word_error`=0, `result_valid` for exactly 1 cycle, 5 cycles per word.
- Equal and less back-to-back: first A=B=8'h5A, then A=8'h3F, B=8'hC0. Required: `word_equal`=1 for the first word, then `word_less`=1 for the second.
- Backpressure: after the 4th digit, hold `result_ready_in`=0 for 6 cycles while `digit_valid_in`=1. Required: `digit_ready`=0, verdict stable, the held digit is not consumed until one cycle after `result_ready_in`=1.
- Illegal flags: flags 3'b000 on digit 1, all other digits EQ. Required: `word_equal`=1, `word_error`=1. The next clean word shows `word_error`=0.
- Mid-word reset: accept 2 digits (GT, EQ), assert `rst` for 1 cycle, then send 4 EQ digits. Required: `word_equal`=1 and the verdict arrives only after the 4 new digits.
